// File: rtl/rk_ctrl_gen.sv
// rk_ctrl_gen: RK8E-class disk controller front end for the PDP-8/e core.
// Decodes the disk IOTs, holds cmd/car/dar/status, and drives a generic
// block-storage backend over a req/ack/done handshake with a watchdog.
module rk_ctrl_gen #(
  parameter logic [5:0]  DEV_CODE   = 6'o74,
  parameter int unsigned NUM_DRIVES = 4,
  parameter int unsigned MAX_CYL    = 202,
  parameter int unsigned TIMEOUT    = 1048576,
  parameter logic [4:0]  F1_STATE   = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [0:11] instruction,
  input  logic [4:0]  state,
  input  logic [0:11] ac,
  input  logic        UF,
  output logic [0:11] disk_bus,
  output logic        interrupt,
  output logic        skip,
  output logic        be_req,
  output logic [1:0]  be_op,
  output logic [2:0]  be_drive,
  output logic [0:12] be_disk_addr,
  output logic [0:14] be_mem_addr,
  output logic        be_len,
  input  logic        be_ack,
  input  logic        be_done,
  input  logic        be_err,
  input  logic [8:0]  be_words
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned EXT_W = (CNT_W < 6) ? 6 : CNT_W;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0] DRV_LIM = 4'(NUM_DRIVES);
  localparam logic [7:0] CYL_LIM = 8'(MAX_CYL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    BUSY    = 3'd2,
    DONE_ST = 3'd3,
    ABORT   = 3'd4
  } fsm_t;

  fsm_t             fsm;
  logic [0:11]      cmd;
  logic [0:11]      car;
  logic [0:11]      dar;
  logic [0:11]      status;
  logic [7:0]       write_lock;
  logic [CNT_W-1:0] wd_cnt;
  logic [8:0]       words_q;
  logic             err_q;

  logic             f1_cyc, iot, caf, sclr, flag, idle;
  logic [2:0]       fn;
  logic             dclc, dclc_abort, dlag;
  logic [7:0]       cyl;
  logic             drv_bad, cyl_bad, lock_bad, is_seek, is_rw;
  logic [EXT_W-1:0] wd_ext;
  logic [5:0]       wd_msb;

  // IOT decode: only in F1 and outside user mode; CAF acts like a clear
  assign f1_cyc     = (state == F1_STATE) && !UF;
  assign fn         = instruction[9:11];
  assign iot        = f1_cyc && (instruction[0:2] == 3'b110) && (instruction[3:8] == DEV_CODE);
  assign caf        = f1_cyc && (instruction == 12'o6007);
  assign sclr       = clear || caf;
  assign flag       = |status;
  assign idle       = (fsm == IDLE);
  assign dclc       = iot && (fn == 3'd2);
  assign dclc_abort = dclc && ac[11];
  assign dlag       = iot && (fn == 3'd3);

  // Command validation for DLAG; cylinder uses the incoming dar value
  assign cyl      = {cmd[11], ac[0:6]};
  assign drv_bad  = {1'b0, cmd[9:11]} >= DRV_LIM;
  assign cyl_bad  = cyl > CYL_LIM;
  assign lock_bad = cmd[0] && !cmd[1] && write_lock[cmd[9:11]];
  assign is_seek  = (cmd[0:2] == 3'b011);
  assign is_rw    = !cmd[1];

  // Diagnostic view of the watchdog: its six most significant bits
  assign wd_ext = EXT_W'(wd_cnt);
  assign wd_msb = 6'(wd_ext >> (EXT_W - 6));

  // Backend address/length fields come straight from the held registers
  assign be_drive     = cmd[9:11];
  assign be_disk_addr = {cmd[11], dar};
  assign be_mem_addr  = {cmd[6:8], car};
  assign be_len       = cmd[5];

  // IOT register updates followed by the transfer FSM (later writes win)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= IDLE;   cmd <= '0;    car <= '0;      dar <= '0;
      status <= '0;  write_lock <= '0; wd_cnt <= '0;
      words_q <= '0; err_q <= 1'b0;
      disk_bus <= '0; interrupt <= 1'b0; skip <= 1'b0;
      be_req <= 1'b0; be_op <= 2'b00;
    end else if (sclr) begin
      fsm <= IDLE;   cmd <= '0;    car <= '0;      dar <= '0;
      status <= '0;  write_lock <= '0; wd_cnt <= '0;
      words_q <= '0; err_q <= 1'b0;
      disk_bus <= '0; interrupt <= 1'b0; skip <= 1'b0;
      be_req <= 1'b0; be_op <= 2'b00;
    end else begin
      disk_bus  <= '0;
      interrupt <= flag & cmd[3];

      if (iot) begin
        skip <= 1'b0;
        case (fn)
          3'd1: skip <= flag;
          3'd2: status <= '0;
          3'd3: begin
            if (idle) dar <= ac;
            else      status[5] <= 1'b1;
          end
          3'd4: car <= ac;
          3'd5: disk_bus <= status;
          3'd6: begin
            if (idle) begin
              cmd    <= ac;
              status <= '0;
              if (ac[0:2] == 3'b010) write_lock[ac[9:11]] <= 1'b1;
            end else begin
              status[5] <= 1'b1;
            end
          end
          3'd7: disk_bus <= {3'b000, 3'(fsm), wd_msb};
          default: ;
        endcase
      end

      case (fsm)
        IDLE: begin
          if (dlag) begin
            if (drv_bad) begin
              status[10] <= 1'b1; status[0] <= 1'b1;
            end else if (cyl_bad) begin
              status[11] <= 1'b1; status[0] <= 1'b1;
            end else if (lock_bad) begin
              status[7] <= 1'b1;  status[0] <= 1'b1;
            end else if (is_seek) begin
              if (cmd[4]) status[0] <= 1'b1;
            end else if (is_rw) begin
              fsm    <= REQ;
              be_req <= 1'b1;
              be_op  <= {1'b0, cmd[0]};
            end else begin
              status[0] <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dclc_abort) begin
            fsm   <= ABORT;
            be_op <= 2'b10;
          end else if (be_ack) begin
            fsm    <= BUSY;
            be_req <= 1'b0;
            wd_cnt <= '0;
          end
        end
        BUSY: begin
          if (be_done) begin
            words_q <= be_words;
            err_q   <= be_err;
            fsm     <= DONE_ST;
          end else if (dclc_abort) begin
            fsm    <= ABORT;
            be_req <= 1'b1;
            be_op  <= 2'b10;
          end else if (wd_cnt == WD_LAST) begin
            status[6] <= 1'b1;
            fsm       <= ABORT;
            be_req    <= 1'b1;
            be_op     <= 2'b10;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        DONE_ST: begin
          car        <= car + 12'(words_q);
          status[0]  <= 1'b1;
          status[10] <= err_q | (status[10] & ~dclc);
          fsm        <= IDLE;
        end
        ABORT: begin
          if (be_ack) begin
            be_req    <= 1'b0;
            status[0] <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
